// File: rtl/br_resolve_unit_if.sv
// Branch-predictor update bundle plus the fetch-redirect handshake.
//  master: EX-stage resolver (drives update bundle and redirect request)
//  slave : predictor / fetch side (returns pred_error and redirect_ready)
//  upd_*          resolved EX instruction info sent to the predictor
//  pred_error     predictor mispredict flag, same cycle as upd_valid
//  redirect_valid fetch redirect request, held until redirect_ready
//  redirect_pc    redirect address, stable while redirect_valid
//  redirect_ready fetch accepts the redirect
interface br_resolve_unit_if;
    logic        upd_valid;
    logic        upd_jump;
    logic        upd_branch;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_call;
    logic        upd_is_ret;
    logic        pred_error;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output upd_valid, upd_jump, upd_branch, upd_pc, upd_taken, upd_target,
               upd_is_call, upd_is_ret, redirect_valid, redirect_pc,
        input  pred_error, redirect_ready
    );

    modport slave (
        input  upd_valid, upd_jump, upd_branch, upd_pc, upd_taken, upd_target,
               upd_is_call, upd_is_ret, redirect_valid, redirect_pc,
        output pred_error, redirect_ready
    );
endinterface

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolver.
// Resolves the EX instruction combinationally, drives the predictor update bundle,
// converts a predictor mispredict into a held fetch redirect and counts branches and
// mispredicts with saturating counters.
//  cpu_clk, cpu_rst   clock, synchronous active-high reset
//  ex_*               EX instruction: valid, pc, opcode, register indices and operands
//  suspend            pipeline stall, EX instruction held
//  upd                update bundle / redirect handshake (master side)
//  link_val           pc+4 write-back value for BL/JIRL
//  flush              kill IF/ID this cycle
//  perf_br_cnt        resolved branch/jump count
//  perf_mis_cnt       mispredict count
module br_resolve_unit #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned LINK_REG = 1
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic               ex_valid_in,
    input  logic [31:0]        ex_pc_in,
    input  logic [3:0]         ex_op,
    input  logic [4:0]         ex_rj,
    input  logic [4:0]         ex_rd,
    input  logic [31:0]        ex_rj_val,
    input  logic [31:0]        ex_rd_val,
    input  logic [31:0]        ex_offs,
    input  logic               suspend,
    br_resolve_unit_if.master  upd,
    output logic [31:0]        link_val,
    output logic               flush,
    output logic [CNT_W-1:0]   perf_br_cnt,
    output logic [CNT_W-1:0]   perf_mis_cnt
);

    localparam logic [4:0]       LinkIdx = 5'(LINK_REG);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [0:0] {StIdle, StRedir} state_e;

    state_e            state_q, state_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

    logic        taken, is_jump, is_branch, is_jirl, is_call, is_ret;
    logic [31:0] pc_plus4, real_target;
    logic        fire;

    // Resolve the EX instruction.
    always_comb begin
        taken     = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        is_jirl   = (ex_op == 4'd9);
        pc_plus4  = ex_pc_in + 32'd4;
        case (ex_op)
            4'd1: begin is_branch = 1'b1; taken = (ex_rj_val == ex_rd_val); end
            4'd2: begin is_branch = 1'b1; taken = (ex_rj_val != ex_rd_val); end
            4'd3: begin is_branch = 1'b1; taken = ($signed(ex_rj_val) <  $signed(ex_rd_val)); end
            4'd4: begin is_branch = 1'b1; taken = ($signed(ex_rj_val) >= $signed(ex_rd_val)); end
            4'd5: begin is_branch = 1'b1; taken = (ex_rj_val <  ex_rd_val); end
            4'd6: begin is_branch = 1'b1; taken = (ex_rj_val >= ex_rd_val); end
            4'd7, 4'd8, 4'd9: begin is_jump = 1'b1; taken = 1'b1; end
            default: ;
        endcase
        if (!taken) begin
            real_target = pc_plus4;
        end else if (is_jirl) begin
            real_target = ex_rj_val + ex_offs;
        end else begin
            real_target = ex_pc_in + ex_offs;
        end
        is_call = (ex_op == 4'd8) | (is_jirl & (ex_rd == LinkIdx));
        // Exclusive with is_call even if the link register were configured as r0.
        is_ret  = is_jirl & (ex_rd == 5'd0) & (ex_rj == LinkIdx) & (ex_offs == 32'd0) & ~is_call;
    end

    // Update bundle; wrong-path EX is squashed while a redirect is outstanding.
    always_comb begin
        upd.upd_valid   = ex_valid_in & (state_q == StIdle) & ~cpu_rst;
        upd.upd_jump    = is_jump   & ~cpu_rst;
        upd.upd_branch  = is_branch & ~cpu_rst;
        upd.upd_taken   = taken     & ~cpu_rst;
        upd.upd_is_call = is_call   & ~cpu_rst;
        upd.upd_is_ret  = is_ret    & ~cpu_rst;
        upd.upd_pc      = cpu_rst ? 32'd0 : ex_pc_in;
        upd.upd_target  = cpu_rst ? 32'd0 : real_target;
        link_val        = pc_plus4;
        fire            = upd.upd_valid & ~suspend;
    end

    // Redirect FSM and counters, next state.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        flush         = 1'b0;
        case (state_q)
            StIdle: begin
                if (fire && upd.pred_error) begin
                    state_d       = StRedir;
                    redirect_pc_d = real_target;
                    flush         = 1'b1;
                end
            end
            StRedir: begin
                flush = 1'b1;
                if (upd.redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (cpu_rst) begin
            flush = 1'b0;
        end
        if (fire && (is_jump || is_branch) && (br_cnt_q != CntMax)) begin
            br_cnt_d = br_cnt_q + CntOne;
        end
        if (fire && upd.pred_error && (mis_cnt_q != CntMax)) begin
            mis_cnt_d = mis_cnt_q + CntOne;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= StIdle;
            redirect_pc_q <= 32'd0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign upd.redirect_valid = (state_q == StRedir);
    assign upd.redirect_pc    = redirect_pc_q;
    assign perf_br_cnt        = br_cnt_q;
    assign perf_mis_cnt       = mis_cnt_q;

endmodule
